// File: rtl/yuv_quant_stream.sv
// yuv_quant_stream: streaming DCT coefficient quantiser.
// Coefficients arrive one per beat, channel-interleaved block by block. Each
// one is multiplied by a reciprocal from a programmable table, then shifted,
// optionally rounded and saturated. The pipeline has three stages and uses
// valid/ready handshakes on both sides.
// Build option: define YUV_QUANT_ROUND_EN to round half away from zero.
// Without it the result is truncated toward zero and the rounding adder is removed.
module yuv_quant_stream #(
  parameter int unsigned MCU_SIZE       = 8,
  parameter int unsigned DCT_BITWIDTH   = 12,
  parameter int unsigned QUAN_BITWIDTH  = 12,
  parameter int unsigned CHANNELS       = 3,
  parameter int unsigned NUM_TABLES     = 2,
  parameter int unsigned RECIP_BITWIDTH = 17
) (
  input  logic                              clk,
  input  logic                              n_rst,
  input  logic                              s_valid,
  output logic                              s_ready,
  input  logic [DCT_BITWIDTH-1:0]           s_coef,
  input  logic                              s_last,
  output logic                              m_valid,
  input  logic                              m_ready,
  output logic [QUAN_BITWIDTH-1:0]          m_coef,
  output logic [$clog2(CHANNELS):0]         m_chan,
  output logic [2*$clog2(MCU_SIZE)-1:0]     m_index,
  output logic                              m_sat,
  output logic                              m_last,
  input  logic                              tbl_we,
  input  logic [$clog2(NUM_TABLES):0]       tbl_sel,
  input  logic [2*$clog2(MCU_SIZE)-1:0]     tbl_addr,
  input  logic [RECIP_BITWIDTH-1:0]         tbl_data
);

  localparam int unsigned NN    = MCU_SIZE * MCU_SIZE;
  localparam int unsigned IW    = 2 * $clog2(MCU_SIZE);
  localparam int unsigned CW    = $clog2(CHANNELS) + 1;
  localparam int unsigned SHIFT = RECIP_BITWIDTH - 1;
  localparam int unsigned PW    = DCT_BITWIDTH + RECIP_BITWIDTH + 1;
  localparam int unsigned DEPTH = NUM_TABLES * NN;
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [QUAN_BITWIDTH-1:0] QMAX_Q = {1'b0, {(QUAN_BITWIDTH-1){1'b1}}};
  localparam logic [PW-1:0] QMAX_W = PW'(QMAX_Q);
`ifdef YUV_QUANT_ROUND_EN
  localparam logic [PW-1:0] HALF = PW'(1) << (SHIFT - 1);
`endif

  logic                      en;
  logic                      hs;
  logic [IW-1:0]             idx_cnt;
  logic [CW-1:0]             ch_cnt;
  logic                      idx_last;
  logic                      ch_last;
  logic [AW-1:0]             rd_addr;
  logic [AW-1:0]             wr_addr;
  logic                      wr_ok;
  logic [RECIP_BITWIDTH-1:0] tbl_mem [DEPTH];

  logic                      v1, v2;
  logic signed [DCT_BITWIDTH-1:0] coef1;
  logic [RECIP_BITWIDTH-1:0] r1;
  logic [IW-1:0]             idx1, idx2;
  logic [CW-1:0]             ch1, ch2;
  logic                      last1, last2;
  logic signed [PW-1:0]      p2;

  logic [PW-1:0]             mag;
  logic [PW-1:0]             q_full;
  logic [QUAN_BITWIDTH-1:0]  q_mag;
  logic [QUAN_BITWIDTH-1:0]  q_out;
  logic                      sat;

  // Whole pipeline advances together; it only freezes while the output is held.
  assign en       = !m_valid || m_ready;
  assign s_ready  = en;
  assign hs       = s_valid && en;
  assign idx_last = (idx_cnt == IW'(NN - 1));
  assign ch_last  = (ch_cnt == CW'(CHANNELS - 1));

  // Table addressing: channels past the last table share the last one.
  always_comb begin
    if (int'(ch_cnt) < int'(NUM_TABLES) - 1)
      rd_addr = AW'(int'(ch_cnt) * int'(NN) + int'(idx_cnt));
    else
      rd_addr = AW'((int'(NUM_TABLES) - 1) * int'(NN) + int'(idx_cnt));
    wr_ok   = tbl_we && (int'(tbl_sel) < int'(NUM_TABLES));
    wr_addr = AW'(int'(tbl_sel) * int'(NN) + int'(tbl_addr));
  end

  // Reciprocal RAM: written any cycle, never reset.
  always_ff @(posedge clk) begin
    if (wr_ok) tbl_mem[wr_addr] <= tbl_data;
  end

  // Block position counters; a frame end lands on the natural wrap point, so it also zeroes them.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      idx_cnt <= '0;
      ch_cnt  <= '0;
    end else if (hs) begin
      if (idx_last) begin
        idx_cnt <= '0;
        ch_cnt  <= ch_last ? '0 : ch_cnt + CW'(1);
      end else begin
        idx_cnt <= idx_cnt + IW'(1);
      end
    end
  end

  // S1: capture the beat and read its reciprocal (old data on a same-cycle write).
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      v1    <= 1'b0;
      coef1 <= '0;
      r1    <= '0;
      idx1  <= '0;
      ch1   <= '0;
      last1 <= 1'b0;
    end else if (en) begin
      v1    <= hs;
      coef1 <= s_coef;
      r1    <= tbl_mem[rd_addr];
      idx1  <= idx_cnt;
      ch1   <= ch_cnt;
      last1 <= s_last && idx_last && ch_last;
    end
  end

  // S2: signed coefficient times unsigned reciprocal.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      v2    <= 1'b0;
      p2    <= '0;
      idx2  <= '0;
      ch2   <= '0;
      last2 <= 1'b0;
    end else if (en) begin
      v2    <= v1;
      p2    <= PW'(coef1) * PW'($signed({1'b0, r1}));
      idx2  <= idx1;
      ch2   <= ch1;
      last2 <= last1;
    end
  end

  // S3 datapath: scale magnitude down, clip, restore sign.
  always_comb begin
    mag = p2[PW-1] ? $unsigned(-p2) : $unsigned(p2);
`ifdef YUV_QUANT_ROUND_EN
    q_full = (mag + HALF) >> SHIFT;
`else
    q_full = mag >> SHIFT;
`endif
    sat   = (q_full > QMAX_W);
    q_mag = sat ? QMAX_Q : q_full[QUAN_BITWIDTH-1:0];
    q_out = p2[PW-1] ? -q_mag : q_mag;
  end

  // S3 output register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      m_valid <= 1'b0;
      m_coef  <= '0;
      m_chan  <= '0;
      m_index <= '0;
      m_sat   <= 1'b0;
      m_last  <= 1'b0;
    end else if (en) begin
      m_valid <= v2;
      m_coef  <= q_out;
      m_chan  <= ch2;
      m_index <= idx2;
      m_sat   <= v2 && sat;
      m_last  <= v2 && last2;
    end
  end

endmodule
